window_scan_ctrl: RTL and testbench
===================================

Name: window_scan_ctrl

Overview:
- Sequences the 4x4 window loader across a feature map of up to MAX_DIM x MAX_DIM int8 pixels.
- For each window position it:
  - issues a 4-row read to the row buffers;
  - pulses the loader's start;
  - waits for its last-row valid;
  - presents the window coordinate to the PE array over a valid/ready handshake.
- Sits between the layer-level sequencer (cfg_start/done) and the row-buffer read port and window loader.

Parameters:
- DIM_W, 8, width of image dimensions and coordinates.
- MAX_DIM, 64, largest legal cfg_width/cfg_height.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cfg_start  in  1  start a scan; sampled only in IDLE
- cfg_width  in  DIM_W  image width in pixels; captured on accepted cfg_start
- cfg_height  in  DIM_W  image height in pixels; captured on accepted cfg_start
- cfg_stride  in  2  window step; 0 is treated as 1; captured on accepted cfg_start
- rd_en  out  1  one-cycle read request to row buffers
- rd_row  out  DIM_W  top row of the window being read (rows rd_row..rd_row+3)
- rd_col  out  DIM_W  left column of the window being read (cols rd_col..rd_col+3)
- win_start  out  1  one-cycle start pulse to the window loader
- win_last_valid  in  1  loader pulse: 4th row loaded
- out_valid  out  1  window complete, coordinate presented
- out_ready  in  1  PE array accepts the window
- out_row  out  DIM_W  row coordinate of the presented window
- out_col  out  DIM_W  column coordinate of the presented window
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at scan end
- cfg_err  out  1  sticky illegal-config flag; cleared on next accepted cfg_start

Behaviour:
- All outputs are registered or Moore-decoded from the state register.
- Reset values: all outputs 0; state IDLE; coordinates 0.
- States and transitions:
  - IDLE: on cfg_start, capture config and clear cfg_err.
    - Legal config: if 4 <= width <= MAX_DIM and 4 <= height <= MAX_DIM, then row=col=0 and go to FETCH.
    - Illegal config: set cfg_err and go to DONE.
  - FETCH: rd_en=1 with rd_row/rd_col = current position, for exactly 1 cycle; go to WAIT_RD.
  - WAIT_RD: 1 cycle; covers the fixed 1-cycle row-buffer read latency; go to LOAD.
  - LOAD: win_start=1 on the first LOAD cycle only. Stay in LOAD until win_last_valid=1, then go to EMIT.
  - EMIT: out_valid=1 and out_row/out_col = current position, held stable until out_ready.
    - On out_valid&&out_ready, advance the position:
      - Column step: ncol = col+stride. If ncol+4 <= width, col=ncol and go to FETCH.
      - Row step: otherwise col=0 and nrow = row+stride. If nrow+4 <= height, row=nrow and go to FETCH.
      - End of scan: otherwise go to DONE.
  - DONE: done=1 for 1 cycle; go to IDLE.
- Arithmetic: all position sums are computed in DIM_W+2 bits, so coordinates never wrap.
- Trailing windows that do not fit (when (dim-4) is not a multiple of stride) are skipped.
- Scan order is row-major. Window count is (floor((W-4)/S)+1) * (floor((H-4)/S)+1).
- Minimum per-window cycles: FETCH 1 + WAIT_RD 1 + LOAD (1 + loader latency) + EMIT >= 1.
- Boundary conditions:
  - cfg_start while busy: ignored; captured config is unchanged.
  - win_last_valid outside LOAD: ignored.
  - win_last_valid in the same cycle as win_start: accepted; LOAD exits next cycle.
  - out_ready without out_valid: no effect.
  - Reset mid-scan: next cycle is IDLE with all outputs 0. No done pulse. No partial window is emitted.
  - cfg_err: DONE still pulses done; no rd_en, win_start or out_valid occurs for that scan.

Decomposition:
- Shared package (sys_types): WIN_DIM=4 constant and the scan_state_t enum (IDLE, FETCH, WAIT_RD, LOAD, EMIT, DONE).
- One natural sub-module: window_pos_stepper.
  - Holds row/col, stride, width and height.
  - Inputs: load, step.
  - Outputs: row, col, last, where last=1 when the next step would leave the image.
- The FSM stays in window_scan_ctrl.

Test Plan:
- 4x4, stride 1, out_ready tied 1, loader model with 4-cycle latency -> exactly one window (0,0); one rd_en with rd_row=0, rd_col=0; done pulses once; cfg_err=0.
- 6x5, stride 1 -> 6 windows in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); 6 rd_en and 6 win_start pulses; then done.
- 8x8, stride 2 -> 9 windows: rows {0,2,4} x cols {0,2,4}, row-major. 7x7, stride 2 -> 4 windows: (0,0),(0,2),(2,0),(2,2).
- 5x5, stride 1, out_ready held 0 for 5 cycles on window (0,1) -> out_valid stays 1 and out_row=0/out_col=1 stay stable; no rd_en during the stall; scan completes with 4 windows.
- cfg_width=3 -> cfg_err=1, done pulses 2 cycles after cfg_start, no rd_en. A following legal start clears cfg_err. cfg_stride=0 on 5x4 behaves as stride 1: windows (0,0),(0,1).
- Reset asserted during EMIT of the 2nd window of a 6x6 scan -> next cycle all outputs 0, busy=0, no done. A new cfg_start restarts at (0,0).

Source files
------------

// File: rtl/sys_types_pkg.sv
// Shared scan types for the window scan controller and its position stepper.
package sys_types;

    localparam int WIN_DIM = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        LOAD,
        EMIT,
        DONE
    } scan_state_t;

endpackage

// File: rtl/window_pos_stepper.sv
// Holds the current window position and the captured scan geometry.
module window_pos_stepper
    import sys_types::*;
#(
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [1:0]       cfg_stride,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last
);

    localparam logic [DIM_W+1:0] WIN = (DIM_W+2)'(WIN_DIM);

    logic [DIM_W-1:0] width_q;
    logic [DIM_W-1:0] height_q;
    logic [1:0]       stride_q;
    logic [DIM_W+1:0] stride_ext;
    logic [DIM_W+1:0] ncol;
    logic [DIM_W+1:0] nrow;
    logic             col_fits;
    logic             row_fits;

    // Wide sums so the fit test can never wrap near the top of the range.
    assign stride_ext = {{DIM_W{1'b0}}, stride_q};
    assign ncol       = {2'b00, col} + stride_ext;
    assign nrow       = {2'b00, row} + stride_ext;
    assign col_fits   = (ncol + WIN) <= {2'b00, width_q};
    assign row_fits   = (nrow + WIN) <= {2'b00, height_q};
    assign last       = !col_fits && !row_fits;

    always_ff @(posedge clk) begin
        if (reset) begin
            row      <= '0;
            col      <= '0;
            width_q  <= '0;
            height_q <= '0;
            stride_q <= 2'd1;
        end else if (load) begin
            row      <= '0;
            col      <= '0;
            width_q  <= cfg_width;
            height_q <= cfg_height;
            stride_q <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
        end else if (step) begin
            if (col_fits) begin
                col <= ncol[DIM_W-1:0];
            end else begin
                col <= '0;
                if (row_fits) begin
                    row <= nrow[DIM_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/window_scan_ctrl.sv
// Walks 4x4 windows over the feature map: read, load, then hand to the PE array.
module window_scan_ctrl
    import sys_types::*;
#(
    parameter int DIM_W   = 8,
    parameter int MAX_DIM = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [1:0]       cfg_stride,
    output logic             rd_en,
    output logic [DIM_W-1:0] rd_row,
    output logic [DIM_W-1:0] rd_col,
    output logic             win_start,
    input  logic             win_last_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIM_W-1:0] out_row,
    output logic [DIM_W-1:0] out_col,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [DIM_W+1:0] WIN     = (DIM_W+2)'(WIN_DIM);
    localparam logic [DIM_W+1:0] MAX_EXT = (DIM_W+2)'(MAX_DIM);

    scan_state_t      state;
    scan_state_t      next_state;
    logic             pos_load;
    logic             pos_step;
    logic             pos_last;
    logic [DIM_W-1:0] pos_row;
    logic [DIM_W-1:0] pos_col;
    logic             cfg_legal;
    logic [DIM_W+1:0] w_ext;
    logic [DIM_W+1:0] h_ext;
    logic             win_start_q;

    assign w_ext     = {2'b00, cfg_width};
    assign h_ext     = {2'b00, cfg_height};
    assign cfg_legal = (w_ext >= WIN) && (w_ext <= MAX_EXT) &&
                       (h_ext >= WIN) && (h_ext <= MAX_EXT);

    window_pos_stepper #(
        .DIM_W (DIM_W)
    ) u_stepper (
        .clk        (clk),
        .reset      (reset),
        .load       (pos_load),
        .step       (pos_step),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_stride (cfg_stride),
        .row        (pos_row),
        .col        (pos_col),
        .last       (pos_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pos_load   = 1'b0;
        pos_step   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    pos_load   = 1'b1;
                    next_state = cfg_legal ? FETCH : DONE;
                end
            end
            FETCH:   next_state = WAIT_RD;
            WAIT_RD: next_state = LOAD;
            LOAD: begin
                if (win_last_valid) begin
                    next_state = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (pos_last) begin
                        next_state = DONE;
                    end else begin
                        pos_step   = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Start pulse only on the first LOAD cycle, however long the loader takes.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_start_q <= 1'b0;
        end else begin
            win_start_q <= (state == WAIT_RD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else if (state == IDLE && cfg_start) begin
            cfg_err <= !cfg_legal;
        end
    end

    assign rd_en     = (state == FETCH);
    assign rd_row    = pos_row;
    assign rd_col    = pos_col;
    assign win_start = win_start_q;
    assign out_valid = (state == EMIT);
    assign out_row   = pos_row;
    assign out_col   = pos_col;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Randomized scoreboard bench for window_scan_ctrl.
module tb_window_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_start = 1'b0;
    logic [7:0] cfg_width = '0;
    logic [7:0] cfg_height = '0;
    logic [1:0] cfg_stride = '0;
    logic       rd_en;
    logic [7:0] rd_row;
    logic [7:0] rd_col;
    logic       win_start;
    logic       win_last_valid = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_row;
    logic [7:0] out_col;
    logic       busy;
    logic       done;
    logic       cfg_err;

    always #5 clk = ~clk;

    window_scan_ctrl #(.DIM_W(8), .MAX_DIM(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_stride     (cfg_stride),
        .rd_en          (rd_en),
        .rd_row         (rd_row),
        .rd_col         (rd_col),
        .win_start      (win_start),
        .win_last_valid (win_last_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row        (out_row),
        .out_col        (out_col),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    int tests = 0;
    int failed = 0;
    int exp_q[$];
    int n_rd = 0, n_ws = 0, n_emit = 0, n_done = 0;
    bit done_seen = 0;
    int fixed_lat = -1;
    int ready_mode = 0;
    int stall_n = 0;
    bit noise = 0;
    int last_cyc = 0;
    bit prev_stall = 0;
    int prev_row = 0, prev_col = 0;
    bit pend = 0;
    int cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Loader model: last-row pulse a configurable number of cycles after start.
    always @(negedge clk) begin
        int lat;
        win_last_valid = 1'b0;
        if (reset) begin
            pend = 0;
        end else if (win_start) begin
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            if (lat == 0) win_last_valid = 1'b1;
            else begin
                pend = 1;
                cnt = lat;
            end
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                win_last_valid = 1'b1;
                pend = 0;
            end
        end else if (noise && $urandom_range(0, 7) == 0) begin
            win_last_valid = 1'b1;
        end
    end

    always @(negedge clk) begin
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (out_valid && out_row == 0 && out_col == 1 && stall_n < 5) begin
                    out_ready = 1'b0;
                    stall_n++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            4: out_ready = (n_emit == 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the expected window list on every accepted handshake.
    always @(negedge clk) begin
        int e;
        #2;
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (rd_en) begin
                n_rd++;
                chk("rd_en_with_valid", int'(out_valid), 0);
                if (exp_q.size() == 0) chk("rd_extra", 1, 0);
                else begin
                    chk("rd_row", int'(rd_row), exp_q[0] / 256);
                    chk("rd_col", int'(rd_col), exp_q[0] % 256);
                end
            end
            if (win_start) n_ws++;
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_row", int'(out_row), prev_row);
                chk("stall_col", int'(out_col), prev_col);
            end
            if (out_valid && out_ready) begin
                n_emit++;
                if (exp_q.size() == 0) chk("emit_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_row", int'(out_row), e / 256);
                    chk("out_col", int'(out_col), e % 256);
                end
            end
            if (done) begin
                n_done++;
                done_seen = 1;
                chk("done_pending", exp_q.size(), 0);
            end
            prev_stall = out_valid && !out_ready;
            prev_row = int'(out_row);
            prev_col = int'(out_col);
        end
    end

    function automatic bit is_legal(input int w, input int h);
        return w >= 4 && w <= 64 && h >= 4 && h <= 64;
    endfunction

    task automatic start_scan(input int w, input int h, input int s);
        int se;
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 0, 1);
        se = (s == 0) ? 1 : s;
        exp_q.delete();
        n_rd = 0; n_ws = 0; n_emit = 0; n_done = 0;
        done_seen = 0; stall_n = 0;
        if (is_legal(w, h))
            for (int r = 0; r + 4 <= h; r += se)
                for (int c = 0; c + 4 <= w; c += se)
                    exp_q.push_back(r * 256 + c);
        cfg_width = 8'(w);
        cfg_height = 8'(h);
        cfg_stride = 2'(s);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic run_scan(input int w, input int h, input int s);
        int nwin;
        int cyc;
        bit lg;
        lg = is_legal(w, h);
        start_scan(w, h, s);
        nwin = exp_q.size();
        cyc = 1;
        while (!done_seen && cyc < 20000) begin
            if (noise && busy && $urandom_range(0, 9) == 0) begin
                cfg_start = 1'b1;
                cfg_width = 8'($urandom);
                cfg_height = 8'($urandom);
                cfg_stride = 2'($urandom);
            end
            @(negedge clk);
            cfg_start = 1'b0;
            cyc++;
        end
        last_cyc = cyc;
        if (!done_seen) chk("scan_timeout", 0, 1);
        chk("n_rd", n_rd, nwin);
        chk("n_win_start", n_ws, nwin);
        chk("n_emit", n_emit, nwin);
        chk("n_done", n_done, 1);
        chk("cfg_err", int'(cfg_err), int'(!lg));
        chk("left_over", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({rd_en, win_start, out_valid, busy, done, cfg_err}), 0);
        chk("reset_coords", int'({rd_row, rd_col, out_row, out_col}), 0);
        reset = 1'b0;
        @(negedge clk);

        fixed_lat = 4;
        ready_mode = 0;
        run_scan(4, 4, 1);
        fixed_lat = -1;
        run_scan(6, 5, 1);
        run_scan(8, 8, 2);
        run_scan(7, 7, 2);

        ready_mode = 2;
        run_scan(5, 5, 1);
        chk("stall_cycles", stall_n, 5);

        ready_mode = 0;
        run_scan(3, 8, 1);
        chk("err_done_lat", last_cyc, 2);
        run_scan(5, 4, 0);

        ready_mode = 4;
        start_scan(6, 6, 1);
        k = 0;
        while (!(n_emit == 1 && out_valid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_emit2", int'(out_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", int'({rd_en, win_start, out_valid, busy, done, cfg_err}), 0);
        chk("rst_mid_coords", int'({rd_row, rd_col, out_row, out_col}), 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("rst_no_done", n_done, 0);
        chk("rst_idle", int'(busy), 0);
        ready_mode = 0;
        run_scan(6, 6, 1);

        noise = 1;
        ready_mode = 1;
        for (int i = 0; i < 20; i++)
            run_scan(int'($urandom_range(2, 20)), int'($urandom_range(2, 20)),
                     int'($urandom_range(0, 3)));
        run_scan(64, 64, 3);
        run_scan(65, 10, 1);
        run_scan(10, 64, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
